maint_scheduler: RTL and testbench
==================================

// Module: maint_scheduler
// PURPOSE
//  Sequences machine maintenance around the main FSM datapath. Counts completed
//  operating cycles and raises a maintenance request when a usage threshold is
//  reached or a manual request M arrives. Runs a req/gnt/done handshake with the
//  service side and keeps the maintenance tally. Drives the 8-bit message
//  (tally, or 8'hFF on lockout) shown by the message register.
// PARAMETERS
//  THRESH       8'd10  op cycles between automatic maintenances (>=1)
//  WARN_MARGIN  8'd2   warn asserted when use_cnt >= THRESH-WARN_MARGIN (<THRESH)
//  TIMEOUT      16     cycles allowed in REQ awaiting maint_gnt before lockout
// PORTS
//  clk         in   1  single clock, rising edge
//  rst         in   1  synchronous, active-high reset
//  op_done     in   1  1-cycle pulse: one machine operating cycle completed
//  M           in   1  manual maintenance request (level, sampled each cycle)
//  fault       in   1  fault indication; forces sticky lockout
//  maint_gnt   in   1  service side accepts request
//  maint_done  in   1  service side finished maintenance
//  maint_req   out  1  maintenance requested (high throughout REQ)
//  maint_busy  out  1  maintenance in progress (high throughout SERVICE)
//  warn        out  1  usage near threshold
//  lockout     out  1  machine locked (LOCK state)
//  msj         out  8  message: maint tally, 8'hFF in LOCK
// BEHAVIOUR
//  - All outputs registered (Moore). Reset: state=RUN, use_cnt=0, tally=0,
//    timer=0; maint_req=maint_busy=warn=lockout=0, msj=8'h00, visible the cycle after rst.
//  - States: RUN, WARN, REQ, SERVICE, LOCK. Priority each cycle: fault > request > warn.
//  - use_cnt (8b): +1 on op_done in RUN/WARN only, saturates at THRESH;
//    op_done ignored in REQ/SERVICE/LOCK.
//  - RUN/WARN: fault -> LOCK; else M or use_cnt_next==THRESH -> REQ;
//    else use_cnt_next>=THRESH-WARN_MARGIN -> WARN, else RUN.
//    Request entered the cycle after the op_done that reaches THRESH.
//  - REQ: timer counts from 0 on entry. maint_gnt -> SERVICE; timer reaching
//    TIMEOUT-1 without gnt -> LOCK (gnt on that same cycle wins -> SERVICE).
//  - SERVICE: maint_done -> RUN, use_cnt cleared, tally+1 saturating at 8'hFE
//    (8'hFF reserved for lockout). fault in SERVICE -> LOCK, no tally increment.
//  - LOCK: sticky until rst; M, gnt, done, op_done ignored.
//  - maint_gnt outside REQ and maint_done outside SERVICE are ignored.
//  - warn = state==WARN; msj = lockout ? 8'hFF : tally.
//  - rst mid-REQ/SERVICE aborts with no tally change; all outputs return to reset values.
// STRUCTURE
//  - maint_pkg: state enum maint_state_t {RUN,WARN,REQ,SERVICE,LOCK},
//    MSG_LOCK=8'hFF, TALLY_MAX=8'hFE.
//  - Sub-module maint_timeout_ctr: clear/enable counter with terminal-count flag (REQ timer).
//  - use_cnt, tally and FSM in maint_scheduler.
// TESTING (THRESH=4, WARN_MARGIN=1, TIMEOUT=8)
//  1 rst; 3 op_done -> warn=1; 4th -> maint_req=1 next cycle; gnt -> busy=1;
//    done -> msj=8'h01, warn=0, use_cnt=0.
//  2 RUN, use_cnt=1, M=1 one cycle -> maint_req=1 next cycle; op_done in REQ ignored.
//  3 REQ, no gnt 8 cycles -> lockout=1, msj=8'hFF; later M/gnt ignored; rst -> msj=8'h00.
//  4 fault with M in same cycle -> LOCK, maint_req never asserted.
//  5 rst during SERVICE -> busy=0, msj=8'h00 next cycle; late maint_done ignored.
//  6 255 full maintenance rounds -> msj saturates at 8'hFE, never 8'hFF outside LOCK.

Source files
------------

// File: rtl/maint_pkg.sv
// Shared types and constants for the maintenance scheduler.
// Holds the FSM state encoding, the reserved message codes and a saturating increment.
package maint_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        WARN    = 3'd1,
        REQ     = 3'd2,
        SERVICE = 3'd3,
        LOCK    = 3'd4
    } maint_state_t;

    localparam logic [7:0] MSG_LOCK  = 8'hFF;
    localparam logic [7:0] TALLY_MAX = 8'hFE;

    function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic [7:0] max);
        return (val >= max) ? max : val + 8'd1;
    endfunction

endpackage

// File: rtl/maint_timeout_ctr.sv
// Clear/enable cycle counter whose flag goes high when the count reaches TIMEOUT-1.
// Used to bound how long a maintenance request may wait for a grant.
module maint_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_r;

    // Count while enabled, holding at the terminal value instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == LAST);

endmodule

// File: rtl/maint_scheduler.sv
// Maintenance scheduler: counts operating cycles, requests service at the usage
// threshold or on manual request, runs the req/gnt/done handshake and keeps the tally.
module maint_scheduler
    import maint_pkg::*;
#(
    parameter logic [7:0] THRESH      = 8'd10,
    parameter logic [7:0] WARN_MARGIN = 8'd2,
    parameter int         TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_done,
    input  logic       M,
    input  logic       fault,
    input  logic       maint_gnt,
    input  logic       maint_done,
    output logic       maint_req,
    output logic       maint_busy,
    output logic       warn,
    output logic       lockout,
    output logic [7:0] msj
);

    maint_state_t state_r, state_nx_s;
    logic [7:0]   use_cnt_r, use_cnt_nx_s;
    logic [7:0]   tally_r, tally_nx_s;
    logic         timeout_s;

    maint_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_req_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_r != REQ),
        .enable (state_r == REQ),
        .tc     (timeout_s)
    );

    // Next-state, usage and tally logic; fault always wins, LOCK only leaves via rst.
    always_comb begin
        state_nx_s   = state_r;
        use_cnt_nx_s = use_cnt_r;
        tally_nx_s   = tally_r;
        case (state_r)
            RUN, WARN: begin
                if (op_done && (use_cnt_r < THRESH)) begin
                    use_cnt_nx_s = use_cnt_r + 8'd1;
                end else begin
                    use_cnt_nx_s = use_cnt_r;
                end
                if (fault) begin
                    state_nx_s = LOCK;
                end else if (M || (use_cnt_nx_s == THRESH)) begin
                    state_nx_s = REQ;
                end else if (use_cnt_nx_s >= (THRESH - WARN_MARGIN)) begin
                    state_nx_s = WARN;
                end else begin
                    state_nx_s = RUN;
                end
            end
            REQ: begin
                if (fault) begin
                    state_nx_s = LOCK;
                end else if (maint_gnt) begin
                    state_nx_s = SERVICE;
                end else if (timeout_s) begin
                    state_nx_s = LOCK;
                end else begin
                    state_nx_s = REQ;
                end
            end
            SERVICE: begin
                if (fault) begin
                    state_nx_s = LOCK;
                end else if (maint_done) begin
                    state_nx_s   = RUN;
                    use_cnt_nx_s = 8'd0;
                    tally_nx_s   = sat_inc(tally_r, TALLY_MAX);
                end else begin
                    state_nx_s = SERVICE;
                end
            end
            LOCK: begin
                state_nx_s = LOCK;
            end
            default: begin
                state_nx_s = LOCK;
            end
        endcase
    end

    // State and Moore outputs, all derived from the next state so they appear with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RUN;
            use_cnt_r  <= 8'd0;
            tally_r    <= 8'd0;
            maint_req  <= 1'b0;
            maint_busy <= 1'b0;
            warn       <= 1'b0;
            lockout    <= 1'b0;
            msj        <= 8'h00;
        end else begin
            state_r    <= state_nx_s;
            use_cnt_r  <= use_cnt_nx_s;
            tally_r    <= tally_nx_s;
            maint_req  <= (state_nx_s == REQ);
            maint_busy <= (state_nx_s == SERVICE);
            warn       <= (state_nx_s == WARN);
            lockout    <= (state_nx_s == LOCK);
            msj        <= (state_nx_s == LOCK) ? MSG_LOCK : tally_nx_s;
        end
    end

endmodule

// File: tb/tb_maint_scheduler.sv
// Directed bench for maint_scheduler with THRESH=4, WARN_MARGIN=1, TIMEOUT=8.
module tb_maint_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       op_done = 1'b0, M = 1'b0, fault = 1'b0, maint_gnt = 1'b0, maint_done = 1'b0;
    logic       maint_req, maint_busy, warn, lockout;
    logic [7:0] msj;
    int         nvec = 0;
    int         nerr = 0;

    maint_scheduler #(.THRESH(8'd4), .WARN_MARGIN(8'd1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .op_done(op_done), .M(M), .fault(fault),
        .maint_gnt(maint_gnt), .maint_done(maint_done), .maint_req(maint_req),
        .maint_busy(maint_busy), .warn(warn), .lockout(lockout), .msj(msj)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1; cyc(); rst = 1'b0;
    endtask

    task automatic pulse_op();
        op_done = 1'b1; cyc(); op_done = 1'b0;
    endtask

    task automatic test_reset();
        op_done = 1'b0; M = 1'b0; fault = 1'b0; maint_gnt = 1'b0; maint_done = 1'b0;
        do_rst();
        nvec++; if ({maint_req, maint_busy, warn, lockout} !== 4'b0000) begin nerr++; $display("FAIL reset_flags got=%b exp=0000", {maint_req, maint_busy, warn, lockout}); end
        nvec++; if (msj !== 8'h00) begin nerr++; $display("FAIL reset_msj got=%h exp=00", msj); end
    endtask

    task automatic test_threshold();
        do_rst();
        pulse_op(); pulse_op();
        nvec++; if (warn !== 1'b0) begin nerr++; $display("FAIL thr_warn2 got=%b exp=0", warn); end
        pulse_op();
        nvec++; if (warn !== 1'b1) begin nerr++; $display("FAIL thr_warn3 got=%b exp=1", warn); end
        nvec++; if (maint_req !== 1'b0) begin nerr++; $display("FAIL thr_req3 got=%b exp=0", maint_req); end
        pulse_op();
        nvec++; if ({maint_req, warn} !== 2'b10) begin nerr++; $display("FAIL thr_req4 got=%b exp=10", {maint_req, warn}); end
        maint_gnt = 1'b1; cyc(); maint_gnt = 1'b0;
        nvec++; if ({maint_req, maint_busy} !== 2'b01) begin nerr++; $display("FAIL thr_busy got=%b exp=01", {maint_req, maint_busy}); end
        maint_done = 1'b1; cyc(); maint_done = 1'b0;
        nvec++; if ({maint_busy, warn} !== 2'b00 || msj !== 8'h01) begin nerr++; $display("FAIL thr_done busy_warn=%b msj=%h exp=00/01", {maint_busy, warn}, msj); end
        // use count restarts from zero: two ops keep warn low, the third raises it
        pulse_op(); pulse_op();
        nvec++; if (warn !== 1'b0) begin nerr++; $display("FAIL thr_clr2 got=%b exp=0", warn); end
        pulse_op();
        nvec++; if (warn !== 1'b1) begin nerr++; $display("FAIL thr_clr3 got=%b exp=1", warn); end
    endtask

    task automatic test_manual();
        do_rst();
        pulse_op();
        M = 1'b1; cyc(); M = 1'b0;
        nvec++; if (maint_req !== 1'b1) begin nerr++; $display("FAIL man_req got=%b exp=1", maint_req); end
        for (int i = 0; i < 4; i++) pulse_op();
        nvec++; if ({maint_req, maint_busy, warn} !== 3'b100) begin nerr++; $display("FAIL man_opign got=%b exp=100", {maint_req, maint_busy, warn}); end
        maint_done = 1'b1; cyc(); maint_done = 1'b0;
        nvec++; if ({maint_req, msj} !== {1'b1, 8'h00}) begin nerr++; $display("FAIL man_doneign req=%b msj=%h exp=1/00", maint_req, msj); end
    endtask

    task automatic test_timeout();
        do_rst();
        M = 1'b1; cyc(); M = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        nvec++; if ({maint_req, lockout} !== 2'b10) begin nerr++; $display("FAIL to_edge got=%b exp=10", {maint_req, lockout}); end
        cyc();
        nvec++; if ({maint_req, lockout} !== 2'b01 || msj !== 8'hFF) begin nerr++; $display("FAIL to_lock flags=%b msj=%h exp=01/ff", {maint_req, lockout}, msj); end
        M = 1'b1; maint_gnt = 1'b1; maint_done = 1'b1; op_done = 1'b1; cyc(); cyc();
        M = 1'b0; maint_gnt = 1'b0; maint_done = 1'b0; op_done = 1'b0;
        nvec++; if ({maint_req, maint_busy, lockout} !== 3'b001 || msj !== 8'hFF) begin nerr++; $display("FAIL to_sticky flags=%b msj=%h exp=001/ff", {maint_req, maint_busy, lockout}, msj); end
        do_rst();
        nvec++; if (lockout !== 1'b0 || msj !== 8'h00) begin nerr++; $display("FAIL to_rst lock=%b msj=%h exp=0/00", lockout, msj); end
        // grant in the last allowed cycle still wins
        M = 1'b1; cyc(); M = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        maint_gnt = 1'b1; cyc(); maint_gnt = 1'b0;
        nvec++; if ({maint_busy, lockout} !== 2'b10) begin nerr++; $display("FAIL to_lastgnt got=%b exp=10", {maint_busy, lockout}); end
    endtask

    task automatic test_fault();
        do_rst();
        fault = 1'b1; M = 1'b1; cyc(); fault = 1'b0; M = 1'b0;
        nvec++; if ({maint_req, lockout} !== 2'b01 || msj !== 8'hFF) begin nerr++; $display("FAIL flt_lock flags=%b msj=%h exp=01/ff", {maint_req, lockout}, msj); end
        M = 1'b1; cyc(); cyc(); M = 1'b0;
        nvec++; if ({maint_req, lockout} !== 2'b01) begin nerr++; $display("FAIL flt_noreq got=%b exp=01", {maint_req, lockout}); end
        // fault during service: no tally increment even with done
        do_rst();
        M = 1'b1; cyc(); M = 1'b0;
        maint_gnt = 1'b1; cyc(); maint_gnt = 1'b0;
        fault = 1'b1; maint_done = 1'b1; cyc(); fault = 1'b0; maint_done = 1'b0;
        nvec++; if ({maint_busy, lockout} !== 2'b01 || msj !== 8'hFF) begin nerr++; $display("FAIL flt_svc flags=%b msj=%h exp=01/ff", {maint_busy, lockout}, msj); end
    endtask

    task automatic test_rst_service();
        do_rst();
        M = 1'b1; cyc(); M = 1'b0;
        maint_gnt = 1'b1; cyc(); maint_gnt = 1'b0;
        maint_done = 1'b1; cyc(); maint_done = 1'b0;
        M = 1'b1; cyc(); M = 1'b0;
        maint_gnt = 1'b1; cyc(); maint_gnt = 1'b0;
        nvec++; if (maint_busy !== 1'b1 || msj !== 8'h01) begin nerr++; $display("FAIL rs_pre busy=%b msj=%h exp=1/01", maint_busy, msj); end
        do_rst();
        nvec++; if (maint_busy !== 1'b0 || msj !== 8'h00) begin nerr++; $display("FAIL rs_abort busy=%b msj=%h exp=0/00", maint_busy, msj); end
        maint_done = 1'b1; cyc(); maint_done = 1'b0;
        nvec++; if (maint_busy !== 1'b0 || msj !== 8'h00) begin nerr++; $display("FAIL rs_late busy=%b msj=%h exp=0/00", maint_busy, msj); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_msj;
        do_rst();
        for (int r = 1; r <= 255; r++) begin
            M = 1'b1; cyc(); M = 1'b0;
            maint_gnt = 1'b1; cyc(); maint_gnt = 1'b0;
            maint_done = 1'b1; cyc(); maint_done = 1'b0;
            exp_msj = (r > 254) ? 8'hFE : 8'(r);
            nvec++; if (msj !== exp_msj || lockout !== 1'b0) begin nerr++; $display("FAIL b2b_round%0d msj=%h lock=%b exp=%h/0", r, msj, lockout, exp_msj); end
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_manual();
        test_timeout();
        test_fault();
        test_rst_service();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
